// File: rtl/div_pkg.sv
// Shared types and constants for the divider issue controller.
package div_pkg;

    typedef struct packed {
        int unsigned TRANS_ID_BITS;
    } div_cfg_t;

    localparam div_cfg_t div_cfg_empty = '{TRANS_ID_BITS: 32'd3};

    typedef enum logic [1:0] {
        DIV_IDLE  = 2'd0,
        DIV_ISSUE = 2'd1,
        DIV_WAIT  = 2'd2,
        DIV_RESP  = 2'd3
    } div_ctrl_state_e;

    // Bit positions inside fu_op_i = {word, rem, signed}
    localparam int unsigned DIV_OP_SIGNED_BIT = 0;
    localparam int unsigned DIV_OP_REM_BIT    = 1;
    localparam int unsigned DIV_OP_WORD_BIT   = 2;

endpackage

// File: rtl/div_issue_ctrl_operand_prep.sv
// Word-op operand conditioning: sign- or zero-extend the low 32 bits of a and b.
module div_operand_prep #(
    parameter int unsigned WIDTH = 64
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             word_i,
    input  logic             signed_i,
    output logic [WIDTH-1:0] a_o,
    output logic [WIDTH-1:0] b_o
);

    always_comb begin
        a_o = a_i;
        b_o = b_i;
        if (word_i) begin
            if (signed_i) begin
                a_o = {{(WIDTH-32){a_i[31]}}, a_i[31:0]};
                b_o = {{(WIDTH-32){b_i[31]}}, b_i[31:0]};
            end else begin
                a_o = {{(WIDTH-32){1'b0}}, a_i[31:0]};
                b_o = {{(WIDTH-32){1'b0}}, b_i[31:0]};
            end
        end
    end

endmodule

// File: rtl/div_issue_ctrl.sv
// Single-entry requester for the serial divider: prepares operands, issues one request,
// collects and finishes the result, and holds it until writeback takes it.
module div_issue_ctrl
    import div_pkg::*;
#(
    parameter div_cfg_t    CVA6Cfg = div_cfg_empty,
    parameter int unsigned WIDTH   = 64
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic                              flush_i,
    input  logic                              fu_valid_i,
    output logic                              fu_ready_o,
    input  logic [2:0]                        fu_op_i,
    input  logic [WIDTH-1:0]                  fu_a_i,
    input  logic [WIDTH-1:0]                  fu_b_i,
    input  logic [CVA6Cfg.TRANS_ID_BITS-1:0]  fu_id_i,
    output logic                              div_vld_o,
    input  logic                              div_rdy_i,
    output logic [CVA6Cfg.TRANS_ID_BITS-1:0]  div_id_o,
    output logic [WIDTH-1:0]                  div_a_o,
    output logic [WIDTH-1:0]                  div_b_o,
    output logic [1:0]                        div_opcode_o,
    output logic                              div_flush_o,
    input  logic                              div_out_vld_i,
    output logic                              div_out_rdy_o,
    input  logic [CVA6Cfg.TRANS_ID_BITS-1:0]  div_out_id_i,
    input  logic [WIDTH-1:0]                  div_res_i,
    output logic                              wb_valid_o,
    input  logic                              wb_ready_i,
    output logic [CVA6Cfg.TRANS_ID_BITS-1:0]  wb_id_o,
    output logic [WIDTH-1:0]                  wb_result_o,
    output logic                              id_mismatch_o,
    output logic [1:0]                        dbg_state_o
);

    // Handshakes: a transfer happens on a cycle where both valid and ready are high at the
    // rising clock edge; valid never depends on ready, and flush aborts without a transfer.

    localparam logic [1:0] S_IDLE  = DIV_IDLE;
    localparam logic [1:0] S_ISSUE = DIV_ISSUE;
    localparam logic [1:0] S_WAIT  = DIV_WAIT;
    localparam logic [1:0] S_RESP  = DIV_RESP;

    logic [1:0]                       state_q;
    logic [WIDTH-1:0]                 a_q, b_q, res_q;
    logic [1:0]                       op_q;
    logic [CVA6Cfg.TRANS_ID_BITS-1:0] id_q;
    logic                             word_q;
    logic                             mismatch_q;

    logic [WIDTH-1:0] prep_a, prep_b, res_fin;

    div_operand_prep #(.WIDTH(WIDTH)) u_operand_prep (
        .a_i      (fu_a_i),
        .b_i      (fu_b_i),
        .word_i   (fu_op_i[DIV_OP_WORD_BIT]),
        .signed_i (fu_op_i[DIV_OP_SIGNED_BIT]),
        .a_o      (prep_a),
        .b_o      (prep_b)
    );

    // Word results are always sign-extended, including unsigned word ops.
    assign res_fin = word_q ? {{(WIDTH-32){div_res_i[31]}}, div_res_i[31:0]} : div_res_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= S_IDLE;
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= '0;
            id_q       <= '0;
            word_q     <= 1'b0;
            res_q      <= '0;
            mismatch_q <= 1'b0;
        end else if (flush_i) begin
            state_q <= S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (fu_valid_i && div_rdy_i) begin
                        state_q <= S_ISSUE;
                        a_q     <= prep_a;
                        b_q     <= prep_b;
                        op_q    <= {fu_op_i[DIV_OP_REM_BIT], fu_op_i[DIV_OP_SIGNED_BIT]};
                        word_q  <= fu_op_i[DIV_OP_WORD_BIT];
                        id_q    <= fu_id_i;
                    end
                end
                S_ISSUE: state_q <= S_WAIT;
                S_WAIT: begin
                    if (div_out_vld_i) begin
                        state_q <= S_RESP;
                        res_q   <= res_fin;
                        if (div_out_id_i != id_q) begin
                            mismatch_q <= 1'b1;
                        end
                    end
                end
                S_RESP: begin
                    if (wb_ready_i) begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign fu_ready_o    = (state_q == S_IDLE) && div_rdy_i && !flush_i;
    assign div_vld_o     = (state_q == S_ISSUE);
    assign div_out_rdy_o = (state_q == S_WAIT);
    assign wb_valid_o    = (state_q == S_RESP);
    assign div_flush_o   = flush_i;
    assign div_id_o      = id_q;
    assign div_a_o       = a_q;
    assign div_b_o       = b_q;
    assign div_opcode_o  = op_q;
    assign wb_id_o       = id_q;
    assign wb_result_o   = res_q;
    assign id_mismatch_o = mismatch_q;
    assign dbg_state_o   = state_q;

endmodule

// File: doc/div_issue_ctrl.md
# div_issue_ctrl

Requester-side controller for the serial divider in the mult functional unit. It accepts one divide/remainder instruction from the issue stage and prepares operands, including 32-bit word variants. It drives the divider's input handshake, collects the divider's result and holds it in a one-entry output register until writeback accepts it. One instruction is in flight at a time, and every path is flush-safe.

## Interface
- `CVA6Cfg`, `config_pkg::cva6_cfg_empty`: configuration; `CVA6Cfg.TRANS_ID_BITS` sets the ID width.
- `WIDTH`, 64: datapath width; must be 64 for word ops (32 ≤ WIDTH).

Ports:
- `clk_i` in 1: clock.
- `rst_ni` in 1: asynchronous reset, active low.
- `flush_i` in 1: kill any in-flight instruction.
- `fu_valid_i` in 1: issue stage presents a div instruction.
- `fu_ready_o` out 1: controller can accept an instruction.
- `fu_op_i` in 3: {word, rem, signed}.
- `fu_a_i`, `fu_b_i` in WIDTH: operands.
- `fu_id_i` in TRANS_ID_BITS: transaction ID.
- `div_vld_o` out 1: request to divider.
- `div_rdy_i` in 1: divider idle.
- `div_id_o` out TRANS_ID_BITS: request ID.
- `div_a_o`, `div_b_o` out WIDTH: prepared operands.
- `div_opcode_o` out 2: {rem, signed}; 0 udiv, 1 div, 2 urem, 3 rem.
- `div_flush_o` out 1: flush forwarded to divider.
- `div_out_vld_i` in 1: divider result valid.
- `div_out_rdy_o` out 1: controller can take the result.
- `div_out_id_i` in TRANS_ID_BITS: result ID.
- `div_res_i` in WIDTH: raw result.
- `wb_valid_o` out 1: result valid to writeback.
- `wb_ready_i` in 1: writeback accepts.
- `wb_id_o` out TRANS_ID_BITS: result ID.
- `wb_result_o` out WIDTH: final result.
- `id_mismatch_o` out 1: sticky error flag; returned ID ≠ issued ID.

## Operation
- **States:** IDLE, ISSUE, WAIT, RESP.
- **IDLE:**
  - `fu_ready_o = div_rdy_i`.
  - On `fu_valid_i & div_rdy_i`, capture the prepared operands, opcode, word flag and ID into registers, then go to ISSUE.
- **ISSUE:**
  - `div_vld_o = 1` for exactly one cycle, with registered operands, opcode and ID.
  - Go to WAIT unconditionally. The divider was observed ready the previous cycle, so its ready is not re-checked.
- **WAIT:**
  - `div_out_rdy_o = 1`.
  - On `div_out_vld_i`, capture the final result into `res_q` and go to RESP.
  - If `div_out_id_i ≠ id_q`, set `id_mismatch_o`. It stays set until reset.
- **RESP:**
  - `wb_valid_o = 1`; `wb_result_o` and `wb_id_o` are held stable.
  - On `wb_ready_i`, go to IDLE.
- **Operand preparation** (word = 1):
  - signed: a = sext(`fu_a_i[31:0]`), b = sext(`fu_b_i[31:0]`).
  - unsigned: zero-extend both operands.
  - word = 0: operands pass through unchanged.
- **Result finishing:**
  - word = 1: `res_q` = sext(`div_res_i[31:0]`), for both signed and unsigned ops.
  - word = 0: `res_q` = `div_res_i`.
- **Flush:**
  - Any state goes to IDLE in the next cycle; `div_flush_o = flush_i` combinationally.
  - Captured operands and any result are dropped, with no `wb_valid_o`.
  - `fu_ready_o = 0` while `flush_i` is high.
- **Simultaneous events:**
  - Flush and `div_out_vld_i` in the same cycle: the result is dropped.
  - Flush and `fu_valid_i` in IDLE: not accepted.
  - Flush with `wb_ready_i` in RESP: treated as a flush; the handshake still counts as done, and no duplicate result is produced.

## Timing
- **Reset values:**
  - State is IDLE; all output registers are 0; `id_mismatch_o = 0`.
  - `div_vld_o`, `div_out_rdy_o` and `wb_valid_o` are 0.
  - `fu_ready_o` follows `div_rdy_i`.
- **Latency:**
  - Accept at cycle T; `div_vld_o` at T+1.
  - The divider result arrives at cycle R ≥ T+2; `wb_valid_o` is asserted from R+1.
  - Total latency is the divider latency plus 2 cycles.
- **Throughput:** IDLE is re-entered the cycle after the writeback handshake, so a new accept is possible at that point. Maximum rate is one instruction per (divider latency + 3) cycles.
- **Outputs:**
  - All datapath outputs are driven from registers.
  - The valid/ready outputs are decoded from state.
  - `div_flush_o` is the only combinational pass-through.

## Structure
- **Shared package** (`ariane_pkg` or a new `div_pkg`):
  - state enum `div_ctrl_state_e`;
  - localparams `DIV_OP_SIGNED_BIT = 0`, `DIV_OP_REM_BIT = 1`, `DIV_OP_WORD_BIT = 2`.
- **Sub-module:** `div_operand_prep`, combinational, handles word sign/zero-extension of a and b. The result sign-extension stays inline.
- **Flops:** state, a_q, b_q, op_q, id_q, word_q, res_q, mismatch_q, all with asynchronous reset.

## Test plan
- **Unsigned 64-bit divide:**
  - Stimulus: op = 000, a = 100, b = 7, id = 3; the model divider returns 14 after 10 cycles.
  - Required: `div_vld_o` one cycle after accept; `wb_result_o = 14`, `wb_id_o = 3`; `wb_valid_o` asserted the cycle after the divider handshake.
- **Word signed remainder:**
  - Stimulus: op = 111, a = 0xFFFF_FFFF_8000_0001, b = 0x0000_0000_0000_0002.
  - Required: `div_a_o` = sext(0x8000_0001) = 0xFFFF_FFFF_8000_0001; opcode = 3.
  - Stimulus: divider returns 0x0000_0000_FFFF_FFFF.
  - Required: `wb_result_o` = 0xFFFF_FFFF_FFFF_FFFF.
- **Word unsigned divide:**
  - Stimulus: op = 100, a = 0xDEAD_BEEF_8000_0000, b = 1.
  - Required: `div_a_o` = 0x0000_0000_8000_0000.
  - Stimulus: divider returns 0x8000_0000.
  - Required: result = 0xFFFF_FFFF_8000_0000.
- **Writeback stall:**
  - Stimulus: hold `wb_ready_i = 0` for 5 cycles.
  - Required: `wb_valid_o`, `wb_result_o` and `wb_id_o` stable; `fu_ready_o = 0`; the op retires on the first `wb_ready_i`.
- **Flush:**
  - Stimulus: flush asserted in WAIT, then the divider returns a result 2 cycles later.
  - Required: `div_flush_o` pulses with the flush; no `wb_valid_o`; `fu_ready_o` returns with `div_rdy_i`.
  - Stimulus: flush in the same cycle as `div_out_vld_i`.
  - Required: the result is dropped.
- **ID mismatch and reset mid-op:**
  - Stimulus: divider returns ID 5 for issued ID 2.
  - Required: `id_mismatch_o = 1`; `wb_id_o = 2`.
  - Stimulus: assert `rst_ni` low in RESP.
  - Required: all outputs return to reset values immediately.
